// File: rtl/sn74ls197_ctl.sv
// sn74ls197_ctl: clears, presets and steps one '197 ripple counter to a target, checking its outputs after each settle window.
module sn74ls197_ctl #(
  parameter int HALF   = 2,
  parameter int SETTLE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] preset,
  input  logic [3:0] target,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] steps,
  output logic       ctr_clr_n,
  output logic       ctr_load_n,
  output logic [3:0] ctr_d,
  output logic       ctr_clk1,
  input  logic [3:0] ctr_q
);
  typedef enum logic [2:0] {IDLE, CLR, LOAD, SET, CLK_HI, CLK_LO, DN} state_t;
  state_t state, nxt;
  logic [7:0] cnt;
  logic [3:0] shadow, tgt;
  logic last_half, last_set, bad;
  assign last_half = cnt == 8'(HALF - 1);
  assign last_set  = cnt == 8'(SETTLE - 1);
  assign bad       = ctr_q != shadow;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? CLR : IDLE;
      CLR:     nxt = last_half ? LOAD : CLR;
      LOAD:    nxt = last_half ? SET : LOAD;
      SET:     nxt = !last_set ? SET : (bad || shadow == tgt) ? DN : CLK_HI;
      CLK_HI:  nxt = last_half ? CLK_LO : CLK_HI;
      CLK_LO:  nxt = last_half ? SET : CLK_LO;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  // pins are registered from the next state so they change together with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      steps      <= '0;
      ctr_clr_n  <= 1'b0;
      ctr_load_n <= 1'b1;
      ctr_clk1   <= 1'b0;
      ctr_d      <= '0;
      shadow     <= '0;
      tgt        <= '0;
    end else begin
      state      <= nxt;
      cnt        <= (nxt != state) ? 8'd0 : cnt + 8'd1;
      busy       <= nxt != IDLE;
      done       <= nxt == DN;
      ctr_clr_n  <= nxt != CLR;
      ctr_load_n <= nxt != LOAD;
      ctr_clk1   <= nxt == CLK_HI;
      if (state == IDLE && nxt == CLR) begin
        ctr_d  <= preset;
        shadow <= preset;
        tgt    <= target;
        steps  <= '0;
        err    <= 1'b0;
      end
      if (state == CLK_HI && nxt == CLK_LO) begin
        shadow <= shadow + 4'd1;
        steps  <= steps + 4'd1;
      end
      if (state == SET && nxt == DN && bad) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sn74ls197_ctl.sv
// tb_sn74ls197_ctl: drives the sequencer against a behavioural '197 and checks completion timing, step counts and error reporting.
module tb_sn74ls197_ctl;
  logic clk = 0, rst = 1, start = 0, abort = 0, fault = 0;
  logic [3:0] preset = 0, target = 0, q = 0;
  logic busy, done, err, ctr_clr_n, ctr_load_n, ctr_clk1;
  logic [3:0] steps, ctr_d, ctr_q;
  int total = 0, bad = 0;

  sn74ls197_ctl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .preset(preset), .target(target),
    .busy(busy), .done(done), .err(err), .steps(steps), .ctr_clr_n(ctr_clr_n),
    .ctr_load_n(ctr_load_n), .ctr_d(ctr_d), .ctr_clk1(ctr_clk1), .ctr_q(ctr_q)
  );

  always #5 clk = ~clk;

  // '197 as a plain 4-bit binary counter: async clear, async load, advance on clk1 falling
  assign ctr_q = fault ? (q & 4'b1011) : q;
  initial begin
    logic prev;
    prev = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!ctr_clr_n) q = 0;
      else if (!ctr_load_n) q = ctr_d;
      else if (prev && !ctr_clk1) q = q + 4'd1;
      prev = ctr_clk1;
    end
  end

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // called in cycle 0 (just after an edge); returns in the done cycle
  task automatic run_op(input logic [3:0] p, input logic [3:0] t, output int dcyc, output int rises, output int nbusy);
    logic prev;
    start = 1; preset = p; target = t;
    tick();
    start = 0;
    dcyc = -1; rises = 0; nbusy = 0; prev = 0;
    for (int c = 1; c < 300; c++) begin
      if (ctr_clk1 && !prev) rises++;
      prev = ctr_clk1;
      if (!busy) nbusy++;
      if (done) begin
        dcyc = c;
        break;
      end
      tick();
    end
  endtask

  typedef struct {
    logic [3:0] p, t;
    logic f;
    int cyc, st, er;
  } vec_t;

  initial begin
    vec_t v[6];
    int dc, rs, nb, seen;
    v[0] = '{4'd5, 4'd9, 1'b0, 36, 4, 0};
    v[1] = '{4'd14, 4'd2, 1'b0, 36, 4, 0};
    v[2] = '{4'd7, 4'd7, 1'b0, 8, 0, 0};
    v[3] = '{4'd3, 4'd6, 1'b1, 15, 1, 1};
    v[4] = '{4'd3, 4'd6, 1'b0, 29, 3, 0};
    v[5] = '{4'd0, 4'd15, 1'b0, 113, 15, 0};

    tick();
    chk("rst_clr_n_1", ctr_clr_n, 0);
    tick();
    chk("rst_clr_n_2", ctr_clr_n, 0);
    rst = 0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_steps", steps, 0);
    chk("rst_clr_n", ctr_clr_n, 1);
    chk("rst_load_n", ctr_load_n, 1);
    chk("rst_clk1", ctr_clk1, 0);
    chk("rst_d", ctr_d, 0);

    foreach (v[i]) begin
      fault = v[i].f;
      run_op(v[i].p, v[i].t, dc, rs, nb);
      chk($sformatf("vec%0d_done_cycle", i), dc, v[i].cyc);
      chk($sformatf("vec%0d_steps", i), steps, v[i].st);
      chk($sformatf("vec%0d_err", i), err, v[i].er);
      chk($sformatf("vec%0d_clk1_rises", i), rs, v[i].st);
      chk($sformatf("vec%0d_busy_gaps", i), nb, 0);
      chk($sformatf("vec%0d_ctr_d", i), ctr_d, v[i].p);
      tick();
      chk($sformatf("vec%0d_done_pulse", i), done, 0);
      chk($sformatf("vec%0d_idle", i), busy, 0);
      if (v[i].f) begin
        tick(); tick();
        chk("err_sticky", err, 1);
      end
      fault = 0;
    end

    for (int k = 0; k < 12; k++) begin
      logic [3:0] p, t;
      int n;
      p = 4'($urandom); t = 4'($urandom);
      n = (int'(t) - int'(p) + 16) % 16;
      run_op(p, t, dc, rs, nb);
      chk($sformatf("rnd%0d_done_cycle p=%0d t=%0d", k, p, t), dc, 8 + 7 * n);
      chk($sformatf("rnd%0d_steps", k), steps, n);
      chk($sformatf("rnd%0d_err", k), err, 0);
      chk($sformatf("rnd%0d_counter", k), ctr_q, t);
      tick();
    end

    // start re-pulsed while busy, then abort mid-step
    seen = 0;
    start = 1; preset = 0; target = 15;
    tick();
    start = 0;
    for (int c = 1; c <= 12; c++) begin
      if (done) seen++;
      start = c == 10;
      if (c == 10) preset = 9;
      abort = c == 12;
      tick();
    end
    abort = 0; start = 0;
    chk("abort_busy", busy, 0);
    chk("abort_clk1", ctr_clk1, 0);
    chk("abort_clr_n", ctr_clr_n, 1);
    chk("abort_load_n", ctr_load_n, 1);
    chk("abort_steps", steps, 1);
    chk("abort_ctr_d", ctr_d, 0);
    for (int c = 0; c < 5; c++) begin
      if (done) seen++;
      tick();
    end
    chk("abort_no_done", seen, 0);

    start = 1; abort = 1; preset = 4;
    tick();
    start = 0; abort = 0;
    chk("start_abort_idle", busy, 0);
    chk("start_abort_d", ctr_d, 0);

    start = 1; preset = 2; target = 10;
    tick();
    start = 0;
    for (int c = 1; c < 5; c++) tick();
    rst = 1;
    tick();
    chk("midrst_clr_n", ctr_clr_n, 0);
    chk("midrst_busy", busy, 0);
    rst = 0;
    tick();
    chk("midrst_clr_n_rel", ctr_clr_n, 1);
    chk("midrst_d", ctr_d, 0);
    chk("midrst_steps", steps, 0);
    chk("midrst_load_n", ctr_load_n, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
